// File: rtl/fractal_sync_pkg.sv
// Shared fractal-sync types and helpers: level-base encoding and the CAM line record.
// CAM line fields are sized for the widest supported configuration; unused upper bits stay zero.
package fractal_sync_pkg;

  localparam int unsigned CAM_SIG_MAX_W = 16;
  localparam int unsigned CAM_AGE_MAX_W = 16;

  typedef struct packed {
    logic                     valid;
    logic [CAM_SIG_MAX_W-1:0] sig;
    logic [CAM_AGE_MAX_W-1:0] age;
  } cam_line_t;

  // Base signature of a tree level; a level that cannot fit returns an out-of-range base.
  function automatic int unsigned level_base(input int unsigned level, input int unsigned sig_width);
    int unsigned b;
    int unsigned r;
    if (level >= sig_width) return 32'(1) << sig_width;
    b = 32'(1) << level;
    r = b;
    for (int unsigned s = 3; s < 32; s += 3) r = r | (b >> s);
    return r & ~32'd1;
  endfunction

endpackage

// File: rtl/fractal_sync_sig_enc.sv
// Combinational (level, id) -> signature encoder with range check.
module fractal_sync_sig_enc
  import fractal_sync_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH = 1,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned N_SIG       = 4,
  parameter int unsigned SIG_WIDTH   = 2
) (
  input  logic [LEVEL_WIDTH-1:0] level_i,
  input  logic [ID_WIDTH-1:0]    id_i,
  output logic [SIG_WIDTH-1:0]   sig_c,
  output logic                   valid_c
);

  logic [32:0] sig_full;

  // Full-width sum so an overflowing level/id never aliases into a legal signature.
  always_comb begin
    sig_full = 33'(level_base(32'(level_i), SIG_WIDTH)) + 33'(id_i);
    sig_c    = SIG_WIDTH'(sig_full);
    valid_c  = (sig_full <= 33'(N_SIG - 1));
  end

endmodule

// File: rtl/fractal_sync_np_remote_cam.sv
// N-port fractal-sync remote CAM: pairs same-signature requests per cycle and parks leftovers in a CAM.
// Stale-line eviction is compiled in with `define FRACTAL_SYNC_CAM_TIMEOUT_EN.
module fractal_sync_np_remote_cam
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned LEVEL_WIDTH    = 1,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned N_LINES        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned N_SIG     = 4 * (2 ** (ID_WIDTH + 2) - 1) / 6,
  localparam int unsigned SIG_WIDTH = $clog2(N_SIG),
  localparam int unsigned OCC_WIDTH = $clog2(N_LINES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [LEVEL_WIDTH-1:0] level_i [N_PORTS],
  input  logic [ID_WIDTH-1:0]    id_i    [N_PORTS],
  input  logic [N_PORTS-1:0]     check_i,
  output logic [N_PORTS-1:0]     ready_o,
  output logic [N_PORTS-1:0]     rsp_valid_o,
  output logic [N_PORTS-1:0]     present_o,
  output logic [N_PORTS-1:0]     bypass_o,
  output logic [N_PORTS-1:0]     sig_err_o,
  output logic [OCC_WIDTH-1:0]   occupancy_o,
  output logic                   full_o,
  output logic                   timeout_o,
  output logic [SIG_WIDTH-1:0]   timeout_sig_o
);

  if (N_PORTS < 2) begin : g_chk_ports
    $error("N_PORTS must be at least 2");
  end
  if (N_LINES < N_PORTS) begin : g_chk_lines
    $error("N_LINES must be at least N_PORTS");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** CAM_AGE_MAX_W) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  if (SIG_WIDTH > CAM_SIG_MAX_W) begin : g_chk_sig
    $error("SIG_WIDTH exceeds CAM line signature field");
  end

  logic [SIG_WIDTH-1:0] sig [N_PORTS];
  logic [N_PORTS-1:0]   sig_ok;
  logic [N_PORTS-1:0]   pair_c;
  logic [N_PORTS-1:0]   hit_c;
  logic [N_PORTS-1:0]   accept;
  logic [N_LINES-1:0]   hit_mask;
  logic [N_LINES-1:0]   alloc_mask;
  logic [OCC_WIDTH-1:0] n_hit;
  logic [OCC_WIDTH-1:0] n_alloc;
  logic [OCC_WIDTH-1:0] occ_d;
  cam_line_t            lines_q [N_LINES];
  cam_line_t            lines_d [N_LINES];

`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
  localparam logic [CAM_AGE_MAX_W-1:0] AGE_MAX  = CAM_AGE_MAX_W'(TIMEOUT_CYCLES);
  localparam logic [CAM_AGE_MAX_W-1:0] AGE_ELIG = CAM_AGE_MAX_W'(TIMEOUT_CYCLES - 1);
  logic                 evict;
  logic [SIG_WIDTH-1:0] evict_sig;
`endif

  for (genvar p = 0; p < N_PORTS; p++) begin : g_enc
    fractal_sync_sig_enc #(
      .LEVEL_WIDTH (LEVEL_WIDTH),
      .ID_WIDTH    (ID_WIDTH),
      .N_SIG       (N_SIG),
      .SIG_WIDTH   (SIG_WIDTH)
    ) u_sig_enc (
      .level_i (level_i[p]),
      .id_i    (id_i[p]),
      .sig_c   (sig[p]),
      .valid_c (sig_ok[p])
    );
  end

  // Port resolution in ascending order: pair, then CAM hit, then allocate into a free line.
  always_comb begin
    logic lower_odd;
    logic higher_any;
    logic found;
    lower_odd  = 1'b0;
    higher_any = 1'b0;
    found      = 1'b0;
    lines_d    = lines_q;
    ready_o    = '0;
    pair_c     = '0;
    hit_c      = '0;
    hit_mask   = '0;
    alloc_mask = '0;
    n_hit      = '0;
    n_alloc    = '0;
`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
    evict      = 1'b0;
    evict_sig  = '0;
    for (int unsigned l = 0; l < N_LINES; l++) begin
      if (lines_q[l].valid && lines_q[l].age < AGE_MAX)
        lines_d[l].age = lines_q[l].age + CAM_AGE_MAX_W'(1);
    end
`endif
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      // Own check is never consulted, so a port's readiness cannot loop through its own valid.
      lower_odd  = 1'b0;
      higher_any = 1'b0;
      for (int unsigned q = 0; q < N_PORTS; q++) begin
        if (q != p && check_i[q] && sig_ok[q] && sig[q] == sig[p]) begin
          if (q < p) lower_odd = ~lower_odd;
          else       higher_any = 1'b1;
        end
      end
      found = 1'b0;
      if (!sig_ok[p]) begin
        ready_o[p] = 1'b1;
      end else if (lower_odd || higher_any) begin
        ready_o[p] = 1'b1;
        pair_c[p]  = 1'b1;
      end else begin
        for (int unsigned l = 0; l < N_LINES; l++) begin
          if (!found && lines_q[l].valid && lines_q[l].sig == CAM_SIG_MAX_W'(sig[p])) begin
            found      = 1'b1;
            ready_o[p] = 1'b1;
            hit_c[p]   = 1'b1;
            if (check_i[p]) begin
              lines_d[l].valid = 1'b0;
              hit_mask[l]      = 1'b1;
              n_hit            = n_hit + OCC_WIDTH'(1);
            end
          end
        end
        // Lines freed by a hit this cycle are still valid in lines_q, so they are not reused yet.
        for (int unsigned l = 0; l < N_LINES; l++) begin
          if (!found && !lines_q[l].valid && !alloc_mask[l]) begin
            found      = 1'b1;
            ready_o[p] = 1'b1;
            if (check_i[p]) begin
              lines_d[l]    = '{valid: 1'b1, sig: CAM_SIG_MAX_W'(sig[p]), age: '0};
              alloc_mask[l] = 1'b1;
              n_alloc       = n_alloc + OCC_WIDTH'(1);
            end
          end
        end
      end
    end
`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
    // One eviction per cycle, lowest line first; a same-cycle hit takes precedence.
    for (int unsigned l = 0; l < N_LINES; l++) begin
      if (!evict && lines_q[l].valid && !hit_mask[l] && lines_q[l].age >= AGE_ELIG) begin
        evict            = 1'b1;
        evict_sig        = SIG_WIDTH'(lines_q[l].sig);
        lines_d[l].valid = 1'b0;
      end
    end
    occ_d = occupancy_o - n_hit - OCC_WIDTH'(evict) + n_alloc;
`else
    occ_d = occupancy_o - n_hit + n_alloc;
`endif
  end

  assign accept = check_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned l = 0; l < N_LINES; l++) lines_q[l] <= '0;
      occupancy_o <= '0;
      full_o      <= 1'b0;
      rsp_valid_o <= '0;
      present_o   <= '0;
      bypass_o    <= '0;
      sig_err_o   <= '0;
    end else begin
      lines_q     <= lines_d;
      occupancy_o <= occ_d;
      full_o      <= (occ_d == OCC_WIDTH'(N_LINES));
      rsp_valid_o <= accept;
      present_o   <= accept & sig_ok & (pair_c | hit_c);
      bypass_o    <= accept & sig_ok & pair_c;
      sig_err_o   <= accept & ~sig_ok;
    end
  end

`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_o     <= 1'b0;
      timeout_sig_o <= '0;
    end else begin
      timeout_o     <= evict;
      timeout_sig_o <= evict_sig;
    end
  end
`else
  assign timeout_o     = 1'b0;
  assign timeout_sig_o = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_np_remote_cam.sv
// Self-checking bench for fractal_sync_np_remote_cam: directed cases plus randomized traffic vs a reference model.
module tb_fractal_sync_np_remote_cam;

  localparam int unsigned NP   = 4;
  localparam int unsigned LW   = 3;
  localparam int unsigned IW   = 3;
  localparam int unsigned NL   = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned NSIG = 20;
  localparam int unsigned SW   = 5;
  localparam int unsigned OW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] level [NP];
  logic [IW-1:0] id    [NP];
  logic [NP-1:0] req_check;
  logic [NP-1:0] ready;
  logic [NP-1:0] rsp_valid;
  logic [NP-1:0] present;
  logic [NP-1:0] bypass;
  logic [NP-1:0] sig_err;
  logic [OW-1:0] occupancy;
  logic          full;
  logic          timeout;
  logic [SW-1:0] timeout_sig;

  fractal_sync_np_remote_cam #(
    .N_PORTS        (NP),
    .LEVEL_WIDTH    (LW),
    .ID_WIDTH       (IW),
    .N_LINES        (NL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .level_i       (level),
    .id_i          (id),
    .check_i       (req_check),
    .ready_o       (ready),
    .rsp_valid_o   (rsp_valid),
    .present_o     (present),
    .bypass_o      (bypass),
    .sig_err_o     (sig_err),
    .occupancy_o   (occupancy),
    .full_o        (full),
    .timeout_o     (timeout),
    .timeout_sig_o (timeout_sig)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference CAM: per-line validity, signature and the edge number at which it was allocated.
  bit m_valid [NL];
  int m_sig   [NL];
  int m_t     [NL];
  int edge_no = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Signature from the level table (0,2,4,8,18 for five-bit signatures); -1 marks out-of-range.
  function automatic int sig_of(input int lv, input int idv);
    int base;
    case (lv)
      0: base = 0;
      1: base = 2;
      2: base = 4;
      3: base = 8;
      4: base = 18;
      default: return -1;
    endcase
    if (base + idv > int'(NSIG) - 1) return -1;
    return base + idv;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < int'(NL); l++) begin
      m_valid[l] = 1'b0;
      m_sig[l]   = 0;
      m_t[l]     = 0;
    end
  endtask

  task automatic clr_req();
    req_check = '0;
    for (int p = 0; p < int'(NP); p++) begin
      level[p] = '0;
      id[p]    = '0;
    end
  endtask

  task automatic set_req(input int p, input int lv, input int idv);
    req_check[p] = 1'b1;
    level[p]     = LW'(lv);
    id[p]        = IW'(idv);
  endtask

  // One clock cycle: predict ready and the registered response, then compare both.
  task automatic step();
    int s [NP];
    bit pair [NP];
    bit rdy [NP];
    bit hitp [NP];
    int open_port [NSIG];
    bit hit_line [NL];
    bit new_line [NL];
    int new_sig [NL];
    bit [NP-1:0] e_rv, e_pr, e_by, e_er;
    int ev;
    int occ;
    #1;
    for (int i = 0; i < int'(NSIG); i++) open_port[i] = -1;
    for (int l = 0; l < int'(NL); l++) begin
      hit_line[l] = 1'b0;
      new_line[l] = 1'b0;
      new_sig[l]  = 0;
    end
    for (int p = 0; p < int'(NP); p++) begin
      s[p]    = sig_of(int'(level[p]), int'(id[p]));
      pair[p] = 1'b0;
      rdy[p]  = 1'b0;
      hitp[p] = 1'b0;
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (req_check[p] && s[p] >= 0) begin
        if (open_port[s[p]] >= 0) begin
          pair[p]               = 1'b1;
          pair[open_port[s[p]]] = 1'b1;
          open_port[s[p]]       = -1;
        end else begin
          open_port[s[p]] = p;
        end
      end
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (!req_check[p]) continue;
      if (s[p] < 0 || pair[p]) begin
        rdy[p] = 1'b1;
        continue;
      end
      for (int l = 0; l < int'(NL); l++) begin
        if (m_valid[l] && m_sig[l] == s[p]) begin
          hitp[p]     = 1'b1;
          rdy[p]      = 1'b1;
          hit_line[l] = 1'b1;
        end
      end
      if (!hitp[p]) begin
        for (int l = 0; l < int'(NL); l++) begin
          if (!rdy[p] && !m_valid[l] && !new_line[l]) begin
            rdy[p]      = 1'b1;
            new_line[l] = 1'b1;
            new_sig[l]  = s[p];
          end
        end
      end
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (req_check[p]) chk_eq($sformatf("ready_p%0d", p), 32'(ready[p]), 32'(rdy[p]));
      e_rv[p] = req_check[p] && rdy[p];
      e_pr[p] = e_rv[p] && (pair[p] || hitp[p]);
      e_by[p] = e_rv[p] && pair[p];
      e_er[p] = e_rv[p] && (s[p] < 0);
    end
    ev = -1;
`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
    for (int l = 0; l < int'(NL); l++) begin
      if (ev < 0 && m_valid[l] && !hit_line[l] && (edge_no + 1 - m_t[l]) >= int'(TO)) ev = l;
    end
`endif
    edge_no++;
    occ = 0;
    for (int l = 0; l < int'(NL); l++) begin
      if (hit_line[l] || l == ev) m_valid[l] = 1'b0;
      if (new_line[l]) begin
        m_valid[l] = 1'b1;
        m_sig[l]   = new_sig[l];
        m_t[l]     = edge_no;
      end
      if (m_valid[l]) occ++;
    end
    @(posedge clk);
    #1;
    chk_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk_eq("present",   32'(present),   32'(e_pr));
    chk_eq("bypass",    32'(bypass),    32'(e_by));
    chk_eq("sig_err",   32'(sig_err),   32'(e_er));
    chk_eq("occupancy", 32'(occupancy), 32'(occ));
    chk_eq("full",      32'(full),      32'(occ == int'(NL)));
    chk_eq("timeout",   32'(timeout),   32'(ev >= 0));
    if (ev >= 0) chk_eq("timeout_sig", 32'(timeout_sig), 32'(m_sig[ev]));
  endtask

  task automatic cyc();
    step();
    @(negedge clk);
    clr_req();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_to;
    clr_req();
    model_reset();
    repeat (2) @(negedge clk);
    chk_eq("rst_occupancy", 32'(occupancy), 32'd0);
    chk_eq("rst_full",      32'(full),      32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_present",   32'(present),   32'd0);
    chk_eq("rst_timeout",   32'(timeout),   32'd0);
    chk_eq("rst_tsig",      32'(timeout_sig), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Same-cycle pair: sig 1 on ports 0 and 1.
    set_req(0, 0, 1); set_req(1, 0, 1);
    cyc();
    chk_eq("pair_bypass", 32'(bypass[1:0]), 32'h3);
    chk_eq("pair_occ",    32'(occupancy),   32'd0);

    // Miss then hit on sig 5 three cycles later.
    set_req(0, 2, 1);
    cyc();
    chk_eq("miss_present", 32'(present[0]), 32'd0);
    chk_eq("miss_occ",     32'(occupancy),  32'd1);
    cyc(); cyc();
    set_req(1, 2, 1);
    cyc();
    chk_eq("hit_present", 32'(present[1]), 32'd1);
    chk_eq("hit_bypass",  32'(bypass[1]),  32'd0);
    chk_eq("hit_occ",     32'(occupancy),  32'd0);

    // Fill every line, then back-pressure a new sig while another port hits.
    set_req(0, 1, 0); set_req(1, 1, 1); set_req(2, 2, 0); set_req(3, 2, 2);
    cyc();
    chk_eq("fill_full", 32'(full), 32'd1);
    set_req(0, 1, 0); set_req(1, 2, 3);
    cyc();
    chk_eq("bp_no_rsp",  32'(rsp_valid[1]), 32'd0);
    chk_eq("bp_hit",     32'(present[0]),   32'd1);
    set_req(1, 2, 3);
    cyc();
    chk_eq("bp_accept", 32'(rsp_valid[1]), 32'd1);
    set_req(0, 1, 1); set_req(1, 2, 0); set_req(2, 2, 2); set_req(3, 2, 3);
    cyc();
    chk_eq("drain_occ", 32'(occupancy), 32'd0);

    // Three-way tie on sig 9: two bypass, one parks in the CAM.
    set_req(0, 3, 1); set_req(1, 3, 1); set_req(2, 3, 1);
    cyc();
    chk_eq("tie_bypass", 32'(bypass[2:0]), 32'h3);
    chk_eq("tie_occ",    32'(occupancy),   32'd1);
    set_req(3, 3, 1);
    cyc();

    // Out-of-range signatures: level 5, and level 4 with id 3 (sig 21).
    set_req(0, 5, 0); set_req(1, 4, 3); set_req(2, 4, 1);
    cyc();
    chk_eq("inv_err",     32'(sig_err[1:0]), 32'h3);
    chk_eq("inv_present", 32'(present[1:0]), 32'h0);
    set_req(3, 4, 1);
    cyc();

    // Stale line: sig 6 with no partner.
    set_req(0, 2, 2);
    cyc();
    first_to = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (timeout && first_to == 0) first_to = k;
    end
`ifdef FRACTAL_SYNC_CAM_TIMEOUT_EN
    chk_eq("timeout_delay", 32'(first_to), 32'(TO));
`else
    chk_eq("timeout_never", 32'(first_to), 32'd0);
    set_req(1, 2, 2);
    cyc();
`endif

    // Randomized traffic biased towards a small signature space.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < int'(NP); p++) begin
        if ($urandom_range(0, 9) < 6) begin
          if ($urandom_range(0, 9) == 0) set_req(p, int'($urandom_range(3, 7)), int'($urandom_range(0, 7)));
          else                           set_req(p, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
      end
      cyc();
    end

    // Asynchronous reset in the middle of a cycle.
    set_req(0, 3, 5);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_occ",  32'(occupancy), 32'd0);
    chk_eq("mid_rst_full", 32'(full),      32'd0);
    chk_eq("mid_rst_rsp",  32'(rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(2, 1, 1); set_req(3, 1, 1);
    cyc();
    set_req(0, 3, 5);
    cyc();
    chk_eq("post_rst_present", 32'(present[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fractal_sync_np_remote_cam.md
# fractal_sync_np_remote_cam

N-port fractal-sync remote CAM: converts per-port (level, id) barrier requests into signatures, pairs same-signature requests arriving in the same cycle, and stores unmatched signatures in an N_LINES-entry CAM until the partner request arrives. It is the successor of the 2-port 1D remote RF and sits in fractal-sync tree nodes with more than two children. Compared with that block it adds a port count parameter, per-port valid/ready back-pressure on CAM-full, registered responses, an occupancy count and optional stale-entry timeout.

## Interface
- N_PORTS, 2: number of request ports; must be ≥ 2.
- LEVEL_WIDTH, 1: width of the level field.
- ID_WIDTH, 1: width of the id field.
- N_LINES, 4: number of CAM lines; must be ≥ N_PORTS (elaboration assertion).
- TIMEOUT_CYCLES, 1024: age, in cycles, at which a CAM line expires; must be ≥ 1.
- localparam N_SIG = 4*(2**(ID_WIDTH+2)-1)/6.
- localparam SIG_WIDTH = $clog2(N_SIG).
- localparam OCC_WIDTH = $clog2(N_LINES+1).
- clk_i  in  1  clock; the block has one clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- level_i[N_PORTS]  in  LEVEL_WIDTH  request level.
- id_i[N_PORTS]  in  ID_WIDTH  request id.
- check_i[N_PORTS]  in  1  request valid.
- ready_o[N_PORTS]  out  1  request accepted this cycle if check_i is also high.
- rsp_valid_o[N_PORTS]  out  1  response valid.
- present_o[N_PORTS]  out  1  synchronisation complete, from a pair or a CAM hit.
- bypass_o[N_PORTS]  out  1  completed by same-cycle pairing.
- sig_err_o[N_PORTS]  out  1  signature out of range.
- occupancy_o  out  OCC_WIDTH  number of valid CAM lines.
- full_o  out  1  occupancy_o == N_LINES.
- timeout_o  out  1  one-cycle pulse when a line is evicted by timeout.
- timeout_sig_o  out  SIG_WIDTH  signature of the evicted line.

## Operation
- **Signature.** sig = level base(level_i) + id_i, using the standard fractal-sync level encoding. The level base is 1<<level, ORed with the upper bits folded in steps of three, with bit 0 cleared. sig is valid iff sig ≤ N_SIG-1.
- **Accept.** A request on port i is accepted when check_i & ready_o.
- **Per-cycle resolution.** Requests are processed in ascending port order.
  - An invalid sig is always ready. It responds with sig_err=1, present=0, bypass=0 and has no CAM effect.
  - Valid requests that share a sig pair up in ascending port order, (lowest, next lowest), and so on. Each paired port is ready and responds with present=1, bypass=1. The CAM is untouched.
  - An odd leftover port goes to the CAM.
  - **CAM hit** (sig stored in a valid line): the port is ready, the line is invalidated, and the response is present=1, bypass=0.
  - **CAM miss:** the port takes the lowest-index free line left after lower ports' allocations and responds with present=0, bypass=0. With no free line left, ready_o=0, nothing is consumed and nothing is allocated.
  - A line freed by a hit is not reusable until the next cycle.
- **Occupancy.** occupancy_o = previous value - hits - timeouts + allocations, updated on the clock edge.
- **Reset values.** All lines invalid; occupancy_o=0, full_o=0, timeout_o=0, timeout_sig_o=0; all rsp_valid_o, present_o, bypass_o and sig_err_o = 0.
- **Reset mid-operation.** Clears stored lines and pending responses immediately and asynchronously.

## Timing
- ready_o is combinational from level_i, id_i and check_i of all ports plus the registered CAM state.
- A missing port's ready_o never depends on its own check_i. It depends only on lower-port allocations and its own sig.
- Responses are registered: rsp_valid_o[i] is high exactly one cycle after acceptance, for one cycle. present_o, bypass_o and sig_err_o are meaningful only while rsp_valid_o is high and are 0 otherwise.
- CAM updates take effect at the acceptance edge. A request in cycle t+1 sees allocations and hits from cycle t.
- occupancy_o and full_o are registered.

## Configuration
- **FRACTAL_SYNC_CAM_TIMEOUT_EN defined.**
  - Each valid line has an age counter of width $clog2(TIMEOUT_CYCLES+1). It is 0 on allocation and increments each cycle, saturating at TIMEOUT_CYCLES.
  - A line whose age reaches TIMEOUT_CYCLES is eligible for eviction. Eviction is limited to one line per cycle, the lowest index first. Other eligible lines wait at their saturated value.
  - On eviction the line is invalidated and timeout_o pulses for one cycle, with timeout_sig_o set to the line's sig.
  - A hit on an eligible line in the same cycle wins: no timeout is raised and a response is issued.
- **Macro undefined.** There are no age counters and lines persist until hit. timeout_o and timeout_sig_o are tied to 0.

## Structure
- fractal_sync_pkg gains:
  - a function computing the level base for a given SIG_WIDTH;
  - the typedef of the CAM line struct {valid, sig, age}.
- Sub-module fractal_sync_sig_enc: combinational, one instance per port, producing sig and valid from level and id.
- Pairing, CAM match, allocation and response registers stay in the top level.

## Test plan
- **Same-cycle pair.** N_PORTS=2: both ports level=0, id=1 → both ready; next cycle rsp_valid=1, present=1, bypass=1; occupancy stays 0.
- **Miss then hit.** Port 0 sig 5 at t → response present=0, occupancy=1. Port 1 sig 5 at t+3 → response present=1, bypass=0, occupancy=0.
- **Full back-pressure.** N_LINES=2: fill with sigs 2 and 3. A new sig 4 → ready_o=0 and no response. In the same cycle, a sig 2 on another port → hit. Sig 4 is accepted the cycle after.
- **Three-way tie.** N_PORTS=4: ports 0, 1, 2 with the same sig → ports 0 and 1 get bypass=1; port 2 is allocated (present=0); occupancy=1.
- **Invalid id.** sig > N_SIG-1 → ready=1, response sig_err=1, present=0; CAM unchanged.
- **Timeout (macro on).** TIMEOUT_CYCLES=8: allocate sig 6, no partner → timeout_o pulses once, exactly 8 cycles after the allocation edge, with timeout_sig_o=6; occupancy returns to 0. The same stimulus with the macro off never raises timeout_o.
